// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: command widths, header codes and arbiter state encoding
package mem_port_arbiter_pkg;
  localparam int TX_CMD_BITS = 4;
  localparam int ARB_STATE_BITS = 2;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 4'h1;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16 = 4'h2;
  typedef enum logic [ARB_STATE_BITS-1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_TX   = 2'd2,
    ST_RX   = 2'd3
  } arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: two requester ports plus the shared memory_interface tx/rx channel
interface mem_port_arbiter_if #(parameter int IO_BITS = 2);
  logic p0_cmd_valid, p0_cmd_started, p0_tx_data_next, p0_tx_done;
  logic p0_rx_started, p0_rx_data_valid, p0_rx_done;
  logic [mem_port_arbiter_pkg::TX_CMD_BITS-1:0] p0_cmd;
  logic [IO_BITS-1:0] p0_tx_data;
  logic p1_cmd_valid, p1_cmd_started, p1_tx_data_next, p1_tx_done;
  logic p1_rx_started, p1_rx_data_valid, p1_rx_done;
  logic [mem_port_arbiter_pkg::TX_CMD_BITS-1:0] p1_cmd;
  logic [IO_BITS-1:0] p1_tx_data;
  logic tx_command_valid, tx_command_started, tx_data_next, tx_done;
  logic rx_started, rx_data_valid, rx_done;
  logic [mem_port_arbiter_pkg::TX_CMD_BITS-1:0] tx_command;
  logic [IO_BITS-1:0] tx_data;
  logic [1:0] grant;
  logic busy;
  modport slave (
    input  p0_cmd_valid, p0_cmd, p0_tx_data, p1_cmd_valid, p1_cmd, p1_tx_data,
    input  tx_command_started, tx_data_next, tx_done, rx_started, rx_data_valid, rx_done,
    output p0_cmd_started, p0_tx_data_next, p0_tx_done, p0_rx_started, p0_rx_data_valid, p0_rx_done,
    output p1_cmd_started, p1_tx_data_next, p1_tx_done, p1_rx_started, p1_rx_data_valid, p1_rx_done,
    output tx_command_valid, tx_command, tx_data, grant, busy
  );
  modport master (
    output p0_cmd_valid, p0_cmd, p0_tx_data, p1_cmd_valid, p1_cmd, p1_tx_data,
    output tx_command_started, tx_data_next, tx_done, rx_started, rx_data_valid, rx_done,
    input  p0_cmd_started, p0_tx_data_next, p0_tx_done, p0_rx_started, p0_rx_data_valid, p0_rx_done,
    input  p1_cmd_started, p1_tx_data_next, p1_tx_done, p1_rx_started, p1_rx_data_valid, p1_rx_done,
    input  tx_command_valid, tx_command, tx_data, grant, busy
  );
endinterface

// File: rtl/mem_port_arbiter_picker.sv
// mem_port_arbiter_picker: data-port priority with a bounded run before the fetch port wins
module mem_port_arbiter_picker #(
  parameter int MAX_DATA_RUN = 4,
  parameter int RUN_BITS = 3
) (
  input  logic                p0_valid,
  input  logic                p1_valid,
  input  logic [RUN_BITS-1:0] run,
  output logic [1:0]          pick
);
  assign pick[0] = p0_valid && (!p1_valid || run < RUN_BITS'(MAX_DATA_RUN));
  assign pick[1] = p1_valid && !pick[0];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory_interface tx/rx channel between the data and fetch ports
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int RUN_BITS = $clog2(MAX_DATA_RUN + 1);
  arb_state_t state, state_n, st;
  logic [1:0] grant_q, grant_n, own, pick;
  logic [RUN_BITS-1:0] run, run_n;
  logic [TX_CMD_BITS-1:0] cmd_q, cmd_n, own_cmd;
  logic own_valid, started, tx_next, tx_fin, rx_st, rx_dv, rx_fin;
  mem_port_arbiter_picker #(.MAX_DATA_RUN(MAX_DATA_RUN), .RUN_BITS(RUN_BITS)) u_picker (
    .p0_valid(bus.p0_cmd_valid),
    .p1_valid(bus.p1_cmd_valid),
    .run(run),
    .pick(pick)
  );
  always_comb begin
    st = reset ? ST_IDLE : state;
    own = reset ? 2'b00 : grant_q;
    own_valid = own[1] ? bus.p1_cmd_valid : own[0] & bus.p0_cmd_valid;
    own_cmd = own[1] ? bus.p1_cmd : bus.p0_cmd;
    started = st == ST_CMD && own_valid && bus.tx_command_started;
    tx_next = st == ST_TX && bus.tx_data_next;
    tx_fin = st == ST_TX && bus.tx_done;
    rx_st = st == ST_RX && bus.rx_started;
    rx_dv = st == ST_RX && bus.rx_data_valid;
    rx_fin = st == ST_RX && bus.rx_done;
    bus.tx_command_valid = st == ST_CMD && own_valid;
    bus.tx_command = st == ST_CMD ? own_cmd : '0;
    bus.tx_data = st != ST_TX ? '0 : own[1] ? bus.p1_tx_data : bus.p0_tx_data;
    bus.p0_cmd_started = own[0] && started;
    bus.p0_tx_data_next = own[0] && tx_next;
    bus.p0_tx_done = own[0] && tx_fin;
    bus.p0_rx_started = own[0] && rx_st;
    bus.p0_rx_data_valid = own[0] && rx_dv;
    bus.p0_rx_done = own[0] && rx_fin;
    bus.p1_cmd_started = own[1] && started;
    bus.p1_tx_data_next = own[1] && tx_next;
    bus.p1_tx_done = own[1] && tx_fin;
    bus.p1_rx_started = own[1] && rx_st;
    bus.p1_rx_data_valid = own[1] && rx_dv;
    bus.p1_rx_done = own[1] && rx_fin;
    bus.grant = own;
    bus.busy = st != ST_IDLE;
  end
  always_comb begin
    state_n = state;
    grant_n = grant_q;
    run_n = run;
    cmd_n = cmd_q;
    unique case (state)
      ST_IDLE: begin
        state_n = pick != 2'b00 ? ST_CMD : ST_IDLE;
        grant_n = pick;
        run_n = !(pick[0] && bus.p1_cmd_valid) ? '0 : run == RUN_BITS'(MAX_DATA_RUN) ? run : run + 1'b1;
      end
      ST_CMD: begin
        state_n = !own_valid ? ST_IDLE : started ? ST_TX : ST_CMD;
        grant_n = own_valid ? grant_q : 2'b00;
        cmd_n = started ? own_cmd : cmd_q;
      end
      ST_TX: begin
        state_n = !bus.tx_done ? ST_TX : cmd_q == TX_HEADER_READ_16 ? ST_RX : ST_IDLE;
        grant_n = state_n == ST_IDLE ? 2'b00 : grant_q;
      end
      ST_RX: begin
        state_n = bus.rx_done ? ST_IDLE : ST_RX;
        grant_n = bus.rx_done ? 2'b00 : grant_q;
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = 2'b00;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      grant_q <= '0;
      run <= '0;
      cmd_q <= '0;
    end else begin
      state <= state_n;
      grant_q <= grant_n;
      run <= run_n;
      cmd_q <= cmd_n;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus randomized checks of mem_port_arbiter against a behavioural model
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  localparam int MAXR = 4;
  logic clk = 0;
  logic reset;
  int n_cmp = 0, n_bad = 0;
  int m_own = -1, m_stage = 0, m_run = 0;
  logic [TX_CMD_BITS-1:0] m_cmd = '0;
  int s1, s0s, s0n, s0d, s1v, s1d;
  mem_port_arbiter_if #(.IO_BITS(2)) bus ();
  mem_port_arbiter #(.MAX_DATA_RUN(MAXR)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic mem_clr();
    bus.tx_command_started = 0;
    bus.tx_data_next = 0;
    bus.tx_done = 0;
    bus.rx_started = 0;
    bus.rx_data_valid = 0;
    bus.rx_done = 0;
  endtask
  task automatic zc();
    s1 = 0; s0s = 0; s0n = 0; s0d = 0; s1v = 0; s1d = 0;
  endtask
  task automatic tick();
    logic live, ov;
    logic [5:0] e, g0, g1;
    logic [TX_CMD_BITS-1:0] oc;
    logic [1:0] od;
    @(negedge clk);
    live = !reset && m_own >= 0;
    ov = live && (m_own == 1 ? bus.p1_cmd_valid : bus.p0_cmd_valid);
    oc = m_own == 1 ? bus.p1_cmd : bus.p0_cmd;
    od = m_own == 1 ? bus.p1_tx_data : bus.p0_tx_data;
    e = {m_stage == 0 && ov && bus.tx_command_started,
         m_stage == 1 && bus.tx_data_next, m_stage == 1 && bus.tx_done,
         m_stage == 2 && bus.rx_started, m_stage == 2 && bus.rx_data_valid, m_stage == 2 && bus.rx_done};
    if (!live) e = '0;
    g0 = {bus.p0_cmd_started, bus.p0_tx_data_next, bus.p0_tx_done, bus.p0_rx_started, bus.p0_rx_data_valid, bus.p0_rx_done};
    g1 = {bus.p1_cmd_started, bus.p1_tx_data_next, bus.p1_tx_done, bus.p1_rx_started, bus.p1_rx_data_valid, bus.p1_rx_done};
    chk("grant", 32'(bus.grant), live ? 32'(1 << m_own) : 0);
    chk("busy", 32'(bus.busy), 32'(live));
    chk("p0_strobes", 32'(g0), m_own == 0 ? 32'(e) : 0);
    chk("p1_strobes", 32'(g1), m_own == 1 ? 32'(e) : 0);
    chk("tx_command", {27'd0, bus.tx_command_valid, bus.tx_command_valid ? bus.tx_command : 4'h0},
        {27'd0, live && m_stage == 0 && ov, (live && m_stage == 0 && ov) ? oc : 4'h0});
    chk("tx_data", 32'(bus.tx_data), (live && m_stage == 1) ? 32'(od) : 0);
    s1 += int'($countones(g1)); s0s += int'(g0[5]); s0n += int'(g0[4]); s0d += int'(g0[3]);
    s1v += int'(g1[1]); s1d += int'(g1[0]);
    if (reset) begin
      m_own = -1; m_run = 0; m_stage = 0;
    end else if (m_own < 0) begin
      if (bus.p0_cmd_valid && (!bus.p1_cmd_valid || m_run < MAXR)) begin
        m_own = 0;
        m_run = bus.p1_cmd_valid ? m_run + 1 : 0;
      end else begin
        if (bus.p1_cmd_valid) m_own = 1;
        m_run = 0;
      end
      m_stage = 0;
    end else if (m_stage == 0) begin
      if (!ov) m_own = -1;
      else if (bus.tx_command_started) begin m_cmd = oc; m_stage = 1; end
    end else if (m_stage == 1) begin
      if (bus.tx_done) begin
        if (m_cmd == TX_HEADER_READ_16) m_stage = 2;
        else m_own = -1;
      end
    end else if (bus.rx_done) m_own = -1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [1:0] seq [10];
    seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    reset = 1;
    bus.p0_cmd_valid = 0; bus.p0_cmd = '0; bus.p0_tx_data = '0;
    bus.p1_cmd_valid = 0; bus.p1_cmd = '0; bus.p1_tx_data = '0;
    mem_clr();
    zc();
    @(posedge clk);
    #1;
    tick();
    tick();
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    reset = 0;
    tick();
    zc();
    bus.p0_cmd_valid = 1; bus.p0_cmd = TX_HEADER_WRITE_16; bus.p0_tx_data = 2'b10;
    tick();
    chk("w_grant", 32'(bus.grant), 32'b01);
    bus.tx_command_started = 1;
    tick();
    mem_clr();
    bus.p0_cmd_valid = 0;
    for (int i = 0; i < 8; i++) begin
      bus.tx_data_next = 1; bus.p0_tx_data = 2'(i);
      tick();
    end
    mem_clr();
    bus.tx_done = 1;
    tick();
    mem_clr();
    chk("w_idle_grant", 32'(bus.grant), 0);
    chk("w_next_cnt", s0n, 8);
    chk("w_done_cnt", s0d, 1);
    chk("w_p1_quiet", s1, 0);
    zc();
    bus.p1_cmd_valid = 1; bus.p1_cmd = TX_HEADER_READ_16;
    tick();
    chk("r_grant", 32'(bus.grant), 32'b10);
    bus.tx_command_started = 1;
    tick();
    mem_clr();
    bus.p1_cmd_valid = 0; bus.p1_cmd = TX_HEADER_WRITE_16;
    bus.tx_done = 1;
    tick();
    mem_clr();
    chk("r_in_rx_busy", 32'(bus.busy), 1);
    bus.rx_started = 1;
    tick();
    mem_clr();
    for (int i = 0; i < 8; i++) begin
      bus.rx_data_valid = 1;
      tick();
    end
    mem_clr();
    bus.rx_done = 1;
    tick();
    mem_clr();
    chk("r_idle_grant", 32'(bus.grant), 0);
    chk("r_rxv_cnt", s1v, 8);
    chk("r_rxd_cnt", s1d, 1);
    bus.p0_cmd_valid = 1; bus.p0_cmd = TX_HEADER_WRITE_16;
    bus.p1_cmd_valid = 1; bus.p1_cmd = TX_HEADER_WRITE_16;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("seq%0d", i), 32'(bus.grant), 32'(seq[i]));
      bus.tx_command_started = 1;
      tick();
      mem_clr();
      bus.tx_done = 1;
      tick();
      mem_clr();
    end
    bus.p0_cmd_valid = 0; bus.p1_cmd_valid = 0;
    tick();
    zc();
    bus.p0_cmd_valid = 1;
    tick();
    chk("ab_grant", 32'(bus.grant), 32'b01);
    bus.p0_cmd_valid = 0; bus.p1_cmd_valid = 1;
    tick();
    chk("ab_idle", 32'(bus.grant), 0);
    chk("ab_no_start", s0s, 0);
    tick();
    chk("ab_p1_grant", 32'(bus.grant), 32'b10);
    bus.tx_command_started = 1;
    tick();
    mem_clr();
    bus.p1_cmd_valid = 0;
    bus.tx_done = 1;
    tick();
    mem_clr();
    zc();
    bus.p1_cmd_valid = 1; bus.p1_cmd = TX_HEADER_READ_16;
    tick();
    bus.tx_command_started = 1;
    tick();
    mem_clr();
    bus.p1_cmd_valid = 0;
    bus.tx_done = 1;
    tick();
    mem_clr();
    bus.rx_data_valid = 1;
    tick();
    mem_clr();
    reset = 1;
    #1;
    chk("mid_rst_grant", 32'(bus.grant), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    tick();
    reset = 0;
    zc();
    bus.rx_done = 1;
    tick();
    mem_clr();
    chk("post_rst_rxd", s1d, 0);
    zc();
    for (int i = 0; i < 3; i++) begin
      bus.tx_done = 1; bus.rx_done = 1; bus.rx_data_valid = 1; bus.tx_data_next = 1; bus.rx_started = 1;
      tick();
    end
    mem_clr();
    chk("spur_busy", 32'(bus.busy), 0);
    chk("spur_strobes", s1 + s0n + s0d, 0);
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 5) == 0) bus.p0_cmd_valid = ~bus.p0_cmd_valid;
      if ($urandom_range(0, 5) == 0) bus.p1_cmd_valid = ~bus.p1_cmd_valid;
      bus.p0_cmd = $urandom_range(0, 3) == 0 ? 4'($urandom) : ($urandom_range(0, 1) ? TX_HEADER_READ_16 : TX_HEADER_WRITE_16);
      bus.p1_cmd = $urandom_range(0, 3) == 0 ? 4'($urandom) : ($urandom_range(0, 1) ? TX_HEADER_READ_16 : TX_HEADER_WRITE_16);
      bus.p0_tx_data = 2'($urandom);
      bus.p1_tx_data = 2'($urandom);
      bus.tx_command_started = $urandom_range(0, 2) == 0;
      bus.tx_data_next = $urandom_range(0, 1) == 0;
      bus.tx_done = $urandom_range(0, 4) == 0;
      bus.rx_started = $urandom_range(0, 3) == 0;
      bus.rx_data_valid = $urandom_range(0, 1) == 0;
      bus.rx_done = $urandom_range(0, 5) == 0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
